// File: rtl/moisture_sampler.sv
// Moisture ADC sampler: periodic serial conversion, 7-bit moisture reading out.
// Latency: conversion period max(sample_period,1)+18 clk; result 1 clk after DONE.
// No backpressure: m_valid is a one-cycle pulse; MOISTURE_AVG_EN adds 4-sample averaging.
module moisture_sampler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] sample_period,
  input  logic       adc_miso,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [6:0] m_sense,
  output logic       m_valid,
  output logic       busy
);

  typedef enum logic [1:0] {S_WAIT, S_SETUP, S_SHIFT, S_DONE} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_cnt;
  logic [6:0] w_cnt_nxt;
  logic [3:0] r_bit;
  logic [3:0] w_bit_nxt;
  logic [7:0] r_raw;
  logic [6:0] w_sp_min;
  logic [6:0] w_result;
  logic       w_cs_n_nxt;
  logic       w_sclk_nxt;
  logic       w_busy_nxt;

  // A zero period would never reach the exit count, so clamp it to one cycle
  assign w_sp_min = (sample_period == 7'd0) ? 7'd1 : sample_period;

  // State register: wait counter and shift-cycle index travel with the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_cnt   <= 7'd1;
      r_bit   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Next-state logic: WAIT counts down, SHIFT runs 16 cycles, then DONE reloads WAIT
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    case (r_state)
      S_WAIT: begin
        if (!enable) begin
          w_cnt_nxt = 7'd1;
        end else if (r_cnt <= 7'd1) begin
          w_state_nxt = S_SETUP;
        end else begin
          w_cnt_nxt = r_cnt - 7'd1;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_SHIFT;
        w_bit_nxt   = 4'd0;
      end
      S_SHIFT: begin
        w_bit_nxt = r_bit + 4'd1;
        if (r_bit == 4'd15) w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = w_sp_min;
      end
    endcase
  end

  // Output decode from the next state so the registered pins line up with the state
  always_comb begin
    w_cs_n_nxt = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT));
    w_sclk_nxt = (w_state_nxt == S_SHIFT) && w_bit_nxt[0];
    w_busy_nxt = (w_state_nxt != S_WAIT);
  end

  // Output registers for the ADC pins, busy flag and result strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      busy     <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      adc_cs_n <= w_cs_n_nxt;
      adc_sclk <= w_sclk_nxt;
      busy     <= w_busy_nxt;
      m_valid  <= (r_state == S_DONE);
    end
  end

  // Capture miso on the edges where sclk rises (end of even SHIFT cycles)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_raw <= 8'd0;
    end else if ((r_state == S_SHIFT) && !r_bit[0]) begin
      r_raw <= {r_raw[6:0], adc_miso};
    end
  end

`ifdef MOISTURE_AVG_EN
  logic [6:0] r_hist [4];
  logic       r_hist_vld;
  logic [6:0] w_hist_nxt [4];
  logic [8:0] w_sum;

  // New history: shift in the fresh sample, or fill all four on the first one
  always_comb begin
    w_hist_nxt[0] = r_raw[7:1];
    w_hist_nxt[1] = r_hist_vld ? r_hist[0] : r_raw[7:1];
    w_hist_nxt[2] = r_hist_vld ? r_hist[1] : r_raw[7:1];
    w_hist_nxt[3] = r_hist_vld ? r_hist[2] : r_raw[7:1];
    w_sum = {2'b00, w_hist_nxt[0]} + {2'b00, w_hist_nxt[1]}
          + {2'b00, w_hist_nxt[2]} + {2'b00, w_hist_nxt[3]};
    w_result = w_sum[8:2];
  end

  // History update once per completed conversion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist_vld <= 1'b0;
      for (int i = 0; i < 4; i++) r_hist[i] <= 7'd0;
    end else if (r_state == S_DONE) begin
      r_hist_vld <= 1'b1;
      for (int i = 0; i < 4; i++) r_hist[i] <= w_hist_nxt[i];
    end
  end
`else
  assign w_result = r_raw[7:1];
`endif

  // Result register: only moves when a full frame has completed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_sense <= 7'd127;
    end else if (r_state == S_DONE) begin
      m_sense <= w_result;
    end
  end

endmodule

// File: tb/tb_moisture_sampler.sv
// Directed bench for moisture_sampler: vector table of conversions plus
// hand sequences for enable drop and reset in the middle of a frame.
module tb_moisture_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [6:0] sample_period;
  logic       adc_miso = 1'b0;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [6:0] m_sense;
  logic       m_valid;
  logic       busy;

  moisture_sampler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_period(sample_period),
    .adc_miso     (adc_miso),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .m_sense      (m_sense),
    .m_valid      (m_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ADC model: presents data MSB first, advancing one bit after each sclk rise
  logic [7:0] data_byte = 8'h00;
  int  rises      = 0;
  int  last_rises = 0;
  bit  prev_sclk  = 1'b0;
  bit  prev_cs    = 1'b1;
  always @(negedge clk) begin
    if (adc_sclk && !prev_sclk) rises++;
    if (adc_cs_n && !prev_cs) begin
      last_rises = rises;
      rises      = 0;
    end
    prev_sclk = adc_sclk;
    prev_cs   = adc_cs_n;
    adc_miso  = (rises < 8) ? data_byte[3'(7 - rises)] : 1'b0;
  end

  int prev_sense;
  int t_prev;

  // Wait (bounded) for m_valid, watching that m_sense holds meanwhile
  task automatic wait_valid(input int budget, output bit ok, output bit held);
    int n;
    ok   = 1'b0;
    held = 1'b1;
    n    = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (m_valid) ok = 1'b1;
      else if (m_sense != prev_sense[6:0]) held = 1'b0;
    end
  endtask

  task automatic wait_busy(input int budget, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (busy) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [6:0] sp;
    logic [7:0] raw;
    int         exp_plain;
    int         exp_avg;
    int         exp_period;
  } vec_t;

  vec_t vecs[8];

  function automatic int pick(input int plain, input int avg);
`ifdef MOISTURE_AVG_EN
    return avg;
`else
    return plain;
`endif
  endfunction

  initial begin
    bit ok;
    bit held;
    bit cs_stayed;
    int exp;

    // {period, raw byte, expected plain, expected averaged, period ending here}
    vecs[0] = '{7'd3,   8'hC8, 100, 100, 19};
    vecs[1] = '{7'd0,   8'hC8, 100, 100, 21};
    vecs[2] = '{7'd1,   8'hC8, 100, 100, 19};
    vecs[3] = '{7'd5,   8'h28,  20,  80, 19};
    vecs[4] = '{7'd3,   8'hB4,  90,  77, 23};
    vecs[5] = '{7'd127, 8'hFF, 127,  84, 21};
    vecs[6] = '{7'd2,   8'h01,   0,  59, 145};
    vecs[7] = '{7'd2,   8'hB4,  90,  76, 20};

    rst_n         = 1'b0;
    enable        = 1'b1;
    sample_period = 7'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_m_sense",  int'(m_sense),  127);
    chk("reset_cs_n",     int'(adc_cs_n), 1);
    chk("reset_sclk",     int'(adc_sclk), 0);
    chk("reset_m_valid",  int'(m_valid),  0);
    chk("reset_busy",     int'(busy),     0);

    prev_sense = 127;
    rst_n      = 1'b1;
    t_prev     = cyc;

    for (int i = 0; i < 8; i++) begin
      sample_period = vecs[i].sp;
      data_byte     = vecs[i].raw;
      exp           = pick(vecs[i].exp_plain, vecs[i].exp_avg);
      wait_valid(400, ok, held);
      chk($sformatf("vec%0d_valid_seen", i), int'(ok), 1);
      chk($sformatf("vec%0d_m_sense", i), int'(m_sense), exp);
      chk($sformatf("vec%0d_hold", i), int'(held), 1);
      chk($sformatf("vec%0d_period", i), cyc - t_prev, vecs[i].exp_period);
      chk($sformatf("vec%0d_sclk_rises", i), last_rises, 8);
      t_prev     = cyc;
      prev_sense = exp;
      @(negedge clk);
      chk($sformatf("vec%0d_valid_pulse_end", i), int'(m_valid), 0);
    end

    // Enable dropped at SHIFT cycle 3: frame must still complete
    data_byte = 8'hB4;
    wait_busy(200, ok);
    chk("drop_setup_seen", int'(ok), 1);
    repeat (4) @(negedge clk);
    chk("drop_shift3_sclk", int'(adc_sclk), 1);
    enable = 1'b0;
    wait_valid(100, ok, held);
    exp = pick(90, 76);
    chk("drop_valid_seen", int'(ok), 1);
    chk("drop_m_sense", int'(m_sense), exp);
    chk("drop_sclk_rises", last_rises, 8);
    prev_sense = exp;
    cs_stayed  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!adc_cs_n || busy) cs_stayed = 1'b0;
    end
    chk("drop_cs_idle", int'(cs_stayed), 1);
    enable = 1'b1;
    @(negedge clk);
    chk("drop_resume_busy", int'(busy), 1);
    chk("drop_resume_cs_n", int'(adc_cs_n), 0);

    // Reset pulse at SHIFT cycle 7 discards the partial frame
    repeat (8) @(negedge clk);
    chk("rst_shift7_sclk", int'(adc_sclk), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_cs_n",    int'(adc_cs_n), 1);
    chk("rst_mid_busy",    int'(busy),     0);
    chk("rst_mid_m_valid", int'(m_valid),  0);
    chk("rst_mid_m_sense", int'(m_sense),  127);
    rst_n      = 1'b1;
    prev_sense = 127;
    t_prev     = cyc;
    data_byte  = 8'h6A;
    @(negedge clk);
    chk("rst_resume_busy", int'(busy), 1);
    wait_valid(100, ok, held);
    chk("rst_valid_seen", int'(ok), 1);
    chk("rst_first_latency", cyc - t_prev, 19);
    chk("rst_hold_127", int'(held), 1);
    chk("rst_m_sense", int'(m_sense), 53);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/moisture_sampler.md
MOISTURE_SAMPLER -- requirements
Module: moisture_sampler

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port enable, input, 1 bit: high permits new conversions to start.
REQ-004 SHALL have port sample_period, input, 7 bits: idle cycles between conversions, in clk units.
REQ-005 SHALL have port adc_miso, input, 1 bit: serial data from the moisture ADC, MSB first.
REQ-006 SHALL have port adc_cs_n, output, 1 bit: ADC chip select, active-low.
REQ-007 SHALL have port adc_sclk, output, 1 bit: ADC serial clock at clk/2, registered.
REQ-008 SHALL have port m_sense, output, 7 bits: moisture reading fed to the irrigation FSM; 127 = wettest.
REQ-009 SHALL have port m_valid, output, 1 bit: one-cycle pulse when m_sense takes a new value.
REQ-010 SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-011 SHALL implement states WAIT, SETUP, SHIFT and DONE; all outputs SHALL be registered.
REQ-012 WAIT: adc_cs_n=1, adc_sclk=0, busy=0; on entry, load the counter with max(sample_period,1), sampling sample_period on the entry edge; decrement once per cycle.
REQ-013 WAIT exit: when counter==1 and enable=1, go to SETUP; when enable=0, hold the counter at 1.
REQ-014 SETUP: one cycle; adc_cs_n=0, adc_sclk=0, busy=1.
REQ-015 SHIFT: exactly 16 cycles; adc_cs_n=0; adc_sclk=0 in cycles 0,2,..14 and 1 in cycles 1,3,..15.
REQ-016 SHIFT capture: at each edge where adc_sclk goes 0->1, shift adc_miso into an 8-bit register, MSB first; 8 bits are captured in total.
REQ-017 DONE: one cycle; adc_cs_n=1, adc_sclk=0, busy=1.
REQ-018 At the edge leaving DONE: update m_sense from the 8-bit raw sample, assert m_valid for exactly one cycle, and go to WAIT.
REQ-019 Conversion period with enable held high SHALL be max(sample_period,1)+18 cycles.
REQ-020 Deasserting enable during SETUP, SHIFT or DONE SHALL NOT abort the conversion; the result SHALL still be delivered.
REQ-021 Changing sample_period outside the WAIT entry edge SHALL have no effect until the next WAIT entry.
REQ-022 m_sense SHALL hold its value between m_valid pulses.

Reset
REQ-023 With rst_n=0 at a clock edge: state=WAIT, counter=1, adc_cs_n=1, adc_sclk=0, busy=0, m_valid=0, m_sense=127, raw shift register and averaging history cleared.
REQ-024 Reset SHALL take precedence in every state, including mid-SHIFT; a partial sample SHALL be discarded with no m_valid.
REQ-025 The first SETUP after reset release SHALL occur on the cycle after release when enable=1.

Configuration
REQ-026 Macro MOISTURE_AVG_EN selects averaging.
REQ-027 Without MOISTURE_AVG_EN: m_sense = raw[7:1].
REQ-028 With MOISTURE_AVG_EN: keep the last four values of raw[7:1]; m_sense = (sum of the four, 9 bits) >> 2, truncating.
REQ-029 With MOISTURE_AVG_EN, the first conversion after reset SHALL fill all four history entries with its value.
REQ-030 Interface, state timing and reset values SHALL be identical with and without the macro.

Verification
REQ-031 Reset: hold rst_n=0 for 2 cycles -> m_sense=127, adc_cs_n=1, adc_sclk=0, m_valid=0, busy=0.
REQ-032 Single conversion: ADC model returns 8'hB4, sample_period=3, enable=1 -> m_sense=90 with m_valid pulses 21 cycles apart; 8 sclk rising edges per frame.
REQ-033 Minimum period: sample_period=0 -> period 19 cycles, identical to sample_period=1.
REQ-034 Averaging (MOISTURE_AVG_EN): raw samples 200,200,200,40 -> m_sense 100,100,100,80; with the macro off -> 100,100,100,20.
REQ-035 Reset mid-frame: rst_n=0 for 1 cycle at SHIFT cycle 7 -> adc_cs_n=1 on the next edge, no m_valid, m_sense=127.
REQ-036 Enable drop: enable=0 at SHIFT cycle 3 -> frame completes with m_valid, then adc_cs_n stays 1; after enable=1, SETUP occurs on the next cycle.
